// File: rtl/nn_pkg.sv
// Shared definitions for the neuron datapath: default widths common with the
// sigmoid activation ROM, a constant-foldable clog2 and a signed clamp helper.
package nn_pkg;

  localparam int NN_DATA_WIDTH   = 16;
  localparam int NN_SIG_IN_WIDTH = 10;

  // Working width of the clamp helper; callers sign-extend into it.
  localparam int SAT_W = 64;
  typedef logic signed [SAT_W-1:0] sat_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // Clamp a signed value to the range of a width-bit two's complement number.
  function automatic sat_t sat_signed(input sat_t value, input int width);
    sat_t hi;
    sat_t lo;
    hi = (sat_t'(1) <<< (width - 1)) - sat_t'(1);
    lo = -hi - sat_t'(1);
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// Sample stream, weight/bias load and activation-index result of one neuron.
// Optional sat_flag is present when NEURON_SAT_FLAG_EN is defined.
interface neuron_mac_if
  import nn_pkg::*;
#(
  parameter int NUM_WEIGHT   = 4,
  parameter int DATA_WIDTH   = NN_DATA_WIDTH,
  parameter int SIG_IN_WIDTH = NN_SIG_IN_WIDTH
);
  localparam int ADDR_W = clog2(NUM_WEIGHT);

  logic                           in_valid;
  logic signed [DATA_WIDTH-1:0]   in_data;
  logic                           w_en;
  logic        [ADDR_W-1:0]       w_addr;
  logic signed [DATA_WIDTH-1:0]   w_data;
  logic                           b_en;
  logic signed [DATA_WIDTH-1:0]   b_data;
  logic                           busy;
  logic                           out_valid;
  logic signed [SIG_IN_WIDTH-1:0] sig_x;

`ifdef NEURON_SAT_FLAG_EN
  logic                           sat_flag;

  modport master (
    output in_valid, in_data, w_en, w_addr, w_data, b_en, b_data,
    input  busy, out_valid, sig_x, sat_flag
  );
  modport slave (
    input  in_valid, in_data, w_en, w_addr, w_data, b_en, b_data,
    output busy, out_valid, sig_x, sat_flag
  );
`else
  modport master (
    output in_valid, in_data, w_en, w_addr, w_data, b_en, b_data,
    input  busy, out_valid, sig_x
  );
  modport slave (
    input  in_valid, in_data, w_en, w_addr, w_data, b_en, b_data,
    output busy, out_valid, sig_x
  );
`endif

endinterface

// File: rtl/neuron_weight_mem.sv
// Per-neuron weight store: one synchronous write port, one asynchronous read
// port. A read that coincides with a write to the same address sees old data.
module neuron_weight_mem
  import nn_pkg::*;
#(
  parameter int NUM_WEIGHT = 4,
  parameter int DATA_WIDTH = NN_DATA_WIDTH,
  localparam int ADDR_W    = clog2(NUM_WEIGHT)
) (
  input  logic                         clk,
  input  logic                         w_en,
  input  logic        [ADDR_W-1:0]     w_addr,
  input  logic signed [DATA_WIDTH-1:0] w_data,
  input  logic        [ADDR_W-1:0]     r_addr,
  output logic signed [DATA_WIDTH-1:0] r_data
);

  logic signed [DATA_WIDTH-1:0] mem [NUM_WEIGHT];
  logic                         addr_ok;

  // Writes beyond the last weight are dropped when the address space is sparse.
  if (NUM_WEIGHT == (1 << ADDR_W)) begin : g_full_range
    assign addr_ok = 1'b1;
  end else begin : g_partial_range
    assign addr_ok = (w_addr < ADDR_W'(NUM_WEIGHT));
  end

  // NOTE: the array has no reset branch so it maps onto plain RAM/LUT storage;
  // weights are always loaded by software before use. Sequential state is
  // assigned with <= so every reader sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (w_en && addr_ok) mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/neuron_mac.sv
// Three-stage multiply-accumulate feeding the sigmoid ROM index: multiply,
// accumulate per frame, then bias/shift/clamp. sat_flag under NEURON_SAT_FLAG_EN.
module neuron_mac
  import nn_pkg::*;
#(
  parameter int NUM_WEIGHT   = 4,
  parameter int DATA_WIDTH   = NN_DATA_WIDTH,
  parameter int FRAC_BITS    = 0,
  parameter int SIG_IN_WIDTH = NN_SIG_IN_WIDTH,
  parameter int SHIFT        = 0
) (
  input logic         clk,
  input logic         rst,
  neuron_mac_if.slave bus
);

  localparam int ADDR_W = clog2(NUM_WEIGHT);
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int ACC_W  = PROD_W + ADDR_W;
  localparam int SUM_W  = ACC_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WEIGHT - 1);

  logic        [ADDR_W-1:0]       cnt;
  logic signed [DATA_WIDTH-1:0]   weight;
  logic signed [DATA_WIDTH-1:0]   bias;

  logic                           p_valid;
  logic                           p_first;
  logic                           p_last;
  logic signed [PROD_W-1:0]       prod;

  logic                           a_last;
  logic signed [ACC_W-1:0]        acc;

  logic signed [SUM_W-1:0]        biased;
  logic signed [SUM_W-1:0]        scaled;
  logic                           out_valid_q;
  logic signed [SIG_IN_WIDTH-1:0] sig_q;

  neuron_weight_mem #(
    .NUM_WEIGHT (NUM_WEIGHT),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_weight_mem (
    .clk    (clk),
    .w_en   (bus.w_en),
    .w_addr (bus.w_addr),
    .w_data (bus.w_data),
    .r_addr (cnt),
    .r_data (weight)
  );

  // Sample index within the frame; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (bus.in_valid) begin
      cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias <= '0;
    end else if (bus.b_en) begin
      bias <= bus.b_data;
    end
  end

  // Stage 1: full-precision product, tagged with its position in the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
      prod    <= '0;
    end else begin
      p_valid <= bus.in_valid;
      if (bus.in_valid) begin
        prod    <= PROD_W'(bus.in_data) * PROD_W'(weight);
        p_first <= (cnt == '0);
        p_last  <= (cnt == LAST_IDX);
      end
    end
  end

  // Stage 2: the first tag restarts the sum, so frames can run back to back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      a_last <= 1'b0;
    end else begin
      a_last <= p_valid & p_last;
      if (p_valid) begin
        acc <= p_first ? ACC_W'(prod) : acc + ACC_W'(prod);
      end
    end
  end

  // One guard bit over the accumulator keeps bias-add and shift overflow-free.
  always_comb begin
    biased = SUM_W'(acc) + (SUM_W'(bias) <<< FRAC_BITS);
    scaled = biased >>> SHIFT;
  end

  // Stage 3: clamp to the ROM index range; sig_x holds between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sig_q       <= '0;
    end else begin
      out_valid_q <= a_last;
      if (a_last) sig_q <= SIG_IN_WIDTH'(sat_signed(SAT_W'(scaled), SIG_IN_WIDTH));
    end
  end

`ifdef NEURON_SAT_FLAG_EN
  logic sat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (a_last) begin
      sat_q <= (sat_signed(SAT_W'(scaled), SIG_IN_WIDTH) != SAT_W'(scaled));
    end
  end

  assign bus.sat_flag = sat_q;
`endif

  assign bus.busy      = (cnt != '0);
  assign bus.out_valid = out_valid_q;
  assign bus.sig_x     = sig_q;

endmodule
